dbi_lane_scheduler: RTL and testbench
=====================================

# dbi_lane_scheduler

Shares one narrow DBI-encoded output lane between several requesters, such as the systolic-array row drains. It arbitrates round-robin among the requesters and accepts one word per grant. Each word is serialized into BW-bit beats, and every beat is DBI-encoded against the last value actually driven on the lane. The block sits between the array's output collectors and the off-array link, where it replaces per-row free-running encoders with one sequenced lane.

## Interface
- NREQ, 4, number of requesters (≥2)
- WORD_W, 16, requester word width; must be a multiple of BW
- BW, 4, lane data width; BEATS = WORD_W/BW
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  per-requester word available
- req_data  in  NREQ*WORD_W  requester i word at bits [i*WORD_W +: WORD_W]
- req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high
- lane_data  out  BW  encoded beat (registered)
- lane_dbi  out  1  beat is inverted (registered)
- lane_valid  out  1  beat present (registered)
- lane_last  out  1  final beat of the word (registered)
- lane_id  out  $clog2(NREQ)  source requester of the current word (registered)
- lane_stall  in  1  downstream did not consume the current beat; hold all lane outputs
- busy  out  1  state is SEND

## Operation
- FSM has two states: IDLE and SEND.
- **IDLE**
  - req_ready equals the round-robin grant: the first i with req_valid[i] high, searched from ptr+1 with modulo-NREQ wrap.
  - On a transfer: capture the word and id, drive beat 0 onto the lane, set beat_cnt=0, set ptr=i, go to SEND.
  - With no req_valid high, req_ready=0 and lane_valid=0.
- **SEND**
  - req_ready=0.
  - On an edge with lane_stall=0 and beat_cnt<BEATS-1: drive beat beat_cnt+1 and increment beat_cnt.
  - On an edge with lane_stall=0 and beat_cnt==BEATS-1: clear lane_valid and lane_last, go to IDLE.
  - On an edge with lane_stall=1: all state and outputs hold.
- Beat order: least-significant BW bits first.
- **DBI encoding**
  - t = popcount(prev ^ raw_beat).
  - If t > BW/2: lane_data=~raw_beat and lane_dbi=1. Otherwise lane_data=raw_beat and lane_dbi=0.
  - A tie (t==BW/2) is not inverted.
  - prev is updated to the driven lane_data only when a beat is loaded onto the lane.
  - prev persists across words and requesters.
- lane_last=1 exactly on beat BEATS-1.
- lane_id is constant for all beats of a word.
- Reset values: state=IDLE, ptr=NREQ-1 (requester 0 wins first), prev=0, beat_cnt=0. Outputs lane_data, lane_dbi, lane_valid, lane_last, lane_id, req_ready and busy are all 0.
- Reset mid-word abandons the word with no re-send. The requester has already seen its handshake.

## Timing
- Handshake at cycle T puts beat 0 on the lane at T+1. Beat k appears at T+1+k when no stall occurs.
- lane_valid falls at T+BEATS+1, which is also the earliest next handshake. That handshake's beat 0 appears at T+BEATS+2.
- Each stall cycle extends the word by one cycle.
- Throughput is one word per BEATS+1 cycles, because of one mandatory IDLE bubble.
- req_ready is combinational from state, ptr and req_valid. It carries no combinational path from req_data or lane_stall.
- lane_stall is ignored while in IDLE.
- Requesters must hold req_data stable while req_valid is high, until the transfer.

## Configuration
- DBI_LANE_ENC_EN defined: DBI encoding as above.
- DBI_LANE_ENC_EN undefined:
  - lane_data=raw_beat and lane_dbi is constant 0.
  - The prev register and popcount logic are removed.
  - Sequencing, arbitration and timing are identical.

## Structure
- Package dbi_lane_pkg holds:
  - the state enum (IDLE, SEND);
  - a popcount function parameterized on BW;
  - the DBI threshold constant BW/2.
- Sub-module dbi_rr_arbiter (NREQ) is combinational plus a registered pointer.
  - Inputs: req_valid, and an advance strobe equal to the transfer.
  - Outputs: the one-hot grant and the encoded index.

## Test plan
- Single word, no stall: req_valid=0001, req_data[15:0]=16'hF0F0, prev=0.
  - Beat 0: raw 0, t=0, sent 0x0, dbi=0.
  - Beat 1: raw F, t=4, sent 0x0, dbi=1.
  - Beat 2: raw 0, t=0, sent 0x0, dbi=0.
  - Beat 3: raw F, t=4, sent 0x0, dbi=1.
  - lane_last on beat 3, lane_id=0, beats at T+1..T+4.
- Round-robin fairness: all four requesters hold req_valid=1 continuously.
  - Grant order is 0,1,2,3,0.
  - Handshakes are exactly 5 cycles apart.
- Stall hold: assert lane_stall for 3 cycles during beat 1 of a word.
  - Beat 1 outputs hold for 3 extra cycles.
  - The word completes at T+7.
  - No beat is skipped or duplicated.
- Tie and persistence:
  - A word with beats 0x3,0xC gives 0x3 (t=2, dbi=0), then 0xC (t=4, inverted to 0x3, dbi=1).
  - The next word's beat 0 is compared against 0x3.
- Reset mid-SEND: assert reset at beat 2.
  - Next cycle: all outputs 0, ptr=NREQ-1.
  - With requesters 1 and 0 both valid, requester 0 is granted next.
- Build with DBI_LANE_ENC_EN undefined and word 16'hF0F0: sent beats are 0x0,0xF,0x0,0xF with lane_dbi=0 throughout.

Source files
------------

// File: rtl/dbi_lane_pkg.sv
// +----------------------------------------------------------------------------
// | dbi_lane_pkg : shared types and helpers for the DBI lane scheduler
// | Revision 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package dbi_lane_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int POP_MAX_W = 64;

  // Counts set bits in the low bw bits of v.
  function automatic int popcount(input logic [POP_MAX_W-1:0] v, input int bw);
    int cnt;
    cnt = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      if (i < bw) cnt = cnt + int'(v[i]);
    end
    return cnt;
  endfunction

  // Inversion happens only when strictly more than half the lane toggles.
  function automatic int dbi_threshold(input int bw);
    return bw / 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dbi_rr_arbiter.sv
// +----------------------------------------------------------------------------
// | dbi_rr_arbiter : round-robin grant searched from ptr+1, pointer moves on advance
// | Revision 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module dbi_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req_valid,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] idx;

  // Scan farthest-to-nearest so the closest valid requester after ptr wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    for (int off = NREQ; off >= 1; off--) begin
      idx = IDW'((int'(ptr) + off) % NREQ);
      if (req_valid[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= IDW'(NREQ - 1);
    end else if (advance) begin
      ptr <= grant_idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dbi_lane_scheduler.sv
// +----------------------------------------------------------------------------
// | dbi_lane_scheduler : round-robin word serializer onto one DBI-encoded lane
// | Encoding enabled by macro DBI_LANE_ENC_EN.  Revision 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module dbi_lane_scheduler
  import dbi_lane_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WORD_W = 16,
  parameter int BW     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WORD_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [BW-1:0]            lane_data,
  output logic                     lane_dbi,
  output logic                     lane_valid,
  output logic                     lane_last,
  output logic [$clog2(NREQ)-1:0]  lane_id,
  input  logic                     lane_stall,
  output logic                     busy
);

  localparam int IDW   = $clog2(NREQ);
  localparam int BEATS = WORD_W / BW;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_t          state, state_nxt;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            xfer;
  logic            last_beat;
  logic [WORD_W-1:0] word_in;
  logic [WORD_W-1:0] shreg;
  logic [CW-1:0]   beat_cnt;
  logic [BW-1:0]   load_raw;
  logic [BW-1:0]   enc_data;
  logic            enc_dbi;

  dbi_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .advance   (xfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign xfer      = (state == IDLE) && (|(req_valid & grant));
  assign last_beat = (beat_cnt == CW'(BEATS - 1));

  always_comb begin
    word_in = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) word_in = req_data[i*WORD_W +: WORD_W];
    end
  end

  // shreg holds the not-yet-driven beats, next one in the low BW bits.
  assign load_raw = (state == IDLE) ? word_in[BW-1:0] : shreg[BW-1:0];

`ifdef DBI_LANE_ENC_EN
  logic [BW-1:0] prev;
  logic          load;

  assign load = xfer || ((state == SEND) && !lane_stall && !last_beat);

  always_comb begin
    enc_data = load_raw;
    enc_dbi  = 1'b0;
    if (popcount(POP_MAX_W'(prev ^ load_raw), BW) > dbi_threshold(BW)) begin
      enc_data = ~load_raw;
      enc_dbi  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= '0;
    end else if (load) begin
      prev <= enc_data;
    end
  end
`else
  assign enc_data = load_raw;
  assign enc_dbi  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = grant;
        if (xfer) state_nxt = SEND;
      end
      SEND: begin
        busy = 1'b1;
        if (!lane_stall && last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_data  <= '0;
      lane_dbi   <= 1'b0;
      lane_valid <= 1'b0;
      lane_last  <= 1'b0;
      lane_id    <= '0;
      beat_cnt   <= '0;
      shreg      <= '0;
    end else if (xfer) begin
      shreg      <= word_in >> BW;
      beat_cnt   <= '0;
      lane_id    <= grant_idx;
      lane_valid <= 1'b1;
      lane_last  <= (BEATS == 1);
      lane_data  <= enc_data;
      lane_dbi   <= enc_dbi;
    end else if ((state == SEND) && !lane_stall) begin
      if (last_beat) begin
        lane_valid <= 1'b0;
        lane_last  <= 1'b0;
      end else begin
        shreg     <= shreg >> BW;
        beat_cnt  <= beat_cnt + CW'(1);
        lane_data <= enc_data;
        lane_dbi  <= enc_dbi;
        lane_last <= (beat_cnt == CW'(BEATS - 2));
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dbi_lane_scheduler.sv
// +----------------------------------------------------------------------------
// | tb_dbi_lane_scheduler : scoreboard bench for dbi_lane_scheduler
// | Revision 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_dbi_lane_scheduler;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  lane_data;
  logic        lane_dbi;
  logic        lane_valid;
  logic        lane_last;
  logic [1:0]  lane_id;
  logic        lane_stall;
  logic        busy;

  dbi_lane_scheduler #(.NREQ(4), .WORD_W(16), .BW(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .lane_data  (lane_data),
    .lane_dbi   (lane_dbi),
    .lane_valid (lane_valid),
    .lane_last  (lane_last),
    .lane_id    (lane_id),
    .lane_stall (lane_stall),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] data;
    logic       dbi;
    logic       last;
    logic [1:0] id;
    int         cyc;
  } beat_t;

  beat_t sbq[$];
  int tests  = 0;
  int failed = 0;

`ifdef DBI_LANE_ENC_EN
  logic [3:0] model_prev = 4'h0;
`endif

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    failed++;
    $display("FAIL %s: got timeout expected event (cycle %0d)", name, cyc);
  endtask

  // Expected beats of one word; k is the cycle the handshake was sampled in.
  task automatic push_word(input int id, input logic [15:0] w, input int k,
                           input int stall_at, input int nstall);
    beat_t      b;
    logic [3:0] raw;
    for (int j = 0; j < 4; j++) begin
      raw    = w[j*4 +: 4];
      b.data = raw;
      b.dbi  = 1'b0;
`ifdef DBI_LANE_ENC_EN
      if ($countones(model_prev ^ raw) > 2) begin
        b.data = ~raw;
        b.dbi  = 1'b1;
      end
      model_prev = b.data;
`endif
      b.last = (j == 3);
      b.id   = 2'(id);
      b.cyc  = k + 1 + j + (((stall_at >= 0) && (j >= stall_at)) ? nstall : 0);
      sbq.push_back(b);
    end
  endtask

  // Monitor: compare every presented beat, retire it only when consumed.
  always @(negedge clk) begin
    if (!reset && lane_valid) begin
      check("ready_low_in_send", int'(req_ready), 0);
      if (sbq.size() == 0) begin
        fail_now("unexpected_beat");
      end else begin
        check("beat_data", int'(lane_data), int'(sbq[0].data));
        check("beat_dbi",  int'(lane_dbi),  int'(sbq[0].dbi));
        check("beat_last", int'(lane_last), int'(sbq[0].last));
        check("beat_id",   int'(lane_id),   int'(sbq[0].id));
        if (!lane_stall) begin
          check("beat_cycle", cyc, sbq[0].cyc);
          void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic send_word(input int id, input logic [15:0] w, input int stall_at,
                           input int nstall, output int k);
    bit got;
    @(posedge clk); #1;
    req_data[id*16 +: 16] = w;
    req_valid[id] = 1'b1;
    got = 1'b0;
    k = -1;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (req_valid[id] && req_ready[id]) begin
        got = 1'b1;
        k = cyc;
      end
    end
    if (!got) begin
      fail_now("handshake_timeout");
      req_valid[id] = 1'b0;
    end else begin
      push_word(id, w, k, stall_at, nstall);
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      if (nstall > 0) begin
        while (cyc < k + 1 + stall_at) begin
          @(posedge clk); #1;
        end
        lane_stall = 1'b1;
        repeat (nstall) @(posedge clk);
        #1 lane_stall = 1'b0;
      end
    end
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 40 && sbq.size() > 0; n++) @(negedge clk);
    if (sbq.size() != 0) begin
      fail_now("drain");
      sbq.delete();
    end
    @(negedge clk);
    check("idle_after_word", int'(busy), 0);
  endtask

  int          k;
  int          prev_k;
  bit          got;
  int          order [5] = '{0, 1, 2, 3, 0};
  logic [15:0] rr_data [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

  initial begin
    reset = 1'b1; req_valid = '0; req_data = '0; lane_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_lane_valid", int'(lane_valid), 0);
    check("rst_lane_data",  int'(lane_data), 0);
    check("rst_lane_dbi",   int'(lane_dbi), 0);
    check("rst_lane_last",  int'(lane_last), 0);
    check("rst_lane_id",    int'(lane_id), 0);
    check("rst_busy",       int'(busy), 0);
    check("rst_req_ready",  int'(req_ready), 0);

    // Alternating nibbles: DBI folds every beat to 0x0
    send_word(0, 16'hF0F0, -1, 0, k);
    wait_drain();

    // Tie stays raw, and prev carries into the next word
    send_word(1, 16'h33C3, -1, 0, k);
    send_word(2, 16'h000C, -1, 0, k);
    wait_drain();

    // Three stall cycles on beat 1
    send_word(3, 16'hA5A5, 1, 3, k);
    wait_drain();

    // All requesters valid: grant order 0,1,2,3,0, five cycles apart
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) req_data[i*16 +: 16] = rr_data[i];
    req_valid = 4'b1111;
    prev_k = -1;
    for (int n = 0; n < 5; n++) begin
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        @(negedge clk);
        if (|(req_valid & req_ready)) got = 1'b1;
      end
      if (!got) begin
        fail_now("rr_timeout");
        break;
      end
      check("rr_grant", int'(req_ready), int'(4'b0001 << order[n]));
      if (n > 0) check("rr_spacing", cyc - prev_k, 5);
      prev_k = cyc;
      push_word(order[n], rr_data[order[n]], cyc, -1, 0);
      @(posedge clk);
    end
    #1 req_valid = '0;
    wait_drain();

    // Reset while beat 2 is on the lane
    send_word(2, 16'h1234, -1, 0, k);
    while (cyc < k + 3) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk);
    sbq.delete();
`ifdef DBI_LANE_ENC_EN
    model_prev = 4'h0;
`endif
    @(negedge clk);
    check("midrst_lane_valid", int'(lane_valid), 0);
    check("midrst_lane_data",  int'(lane_data), 0);
    check("midrst_lane_dbi",   int'(lane_dbi), 0);
    check("midrst_lane_last",  int'(lane_last), 0);
    check("midrst_lane_id",    int'(lane_id), 0);
    check("midrst_busy",       int'(busy), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    req_data[15:0]  = 16'h8421;
    req_data[31:16] = 16'h7777;
    req_valid = 4'b0011;
    @(negedge clk);
    check("midrst_grant", int'(req_ready), 4'b0001);
    push_word(0, 16'h8421, cyc, -1, 0);
    @(posedge clk); #1;
    req_valid = '0;
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish by 100000");
    $fatal(1);
  end

endmodule

`default_nettype wire
